// File: rtl/div_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_sched_pkg : shared widths, limits and FSM state for the rate scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package div_sched_pkg;

  localparam int DEF_CNT_W   = 28;
  localparam int DEF_MIN_DIV = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/period_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// period_counter : 0..cur_div-1 counter with registered period tick and wave
// Rev 1.0
// ---------------------------------------------------------------------------
module period_counter
  import div_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [CNT_W-1:0] cur_div,
  input  logic             clear,
  output logic             boundary,
  output logic             tick_out,
  output logic             wave_out
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wave_q, wave_d;

  assign boundary = (count_q == cur_div - CNT_W'(1));

  // An immediate load restarts the period without announcing a tick.
  always_comb begin
    count_d = (clear || boundary) ? '0 : count_q + CNT_W'(1);
    tick_d  = boundary && !clear;
    wave_d  = (count_q < (cur_div >> 1));
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      wave_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wave_q  <= wave_d;
    end
  end

  assign tick_out = tick_q;
  assign wave_out = wave_q;

endmodule
`default_nettype wire

// File: rtl/divider_rate_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// divider_rate_scheduler : boundary-aligned divisor changes for the wave gen.
// Optional DIV_RANGE_CHECK_EN rejects (instead of clamps) divisors < MIN_DIV.
// Rev 1.0
// ---------------------------------------------------------------------------
module divider_rate_scheduler
  import div_sched_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 100000,
  parameter int MIN_DIV     = DEF_MIN_DIV
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_div,
  input  logic             req_imm,
  output logic             req_ready,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy,
  output logic             tick_out,
`ifdef DIV_RANGE_CHECK_EN
  output logic             wave_out,
  output logic             err_out
`else
  output logic             wave_out
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             busy_q, busy_d;
  logic             boundary;
  logic             clear;
  logic             accept;
  logic             div_ok;
  logic             apply;
  logic [CNT_W-1:0] div_in;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign div_ok    = (req_div >= CNT_W'(MIN_DIV));

`ifdef DIV_RANGE_CHECK_EN
  logic err_q, err_d;
  assign apply   = accept && div_ok;
  assign div_in  = req_div;
  assign err_d   = err_q || (accept && !div_ok);
  assign err_out = err_q;

  always_ff @(posedge clock_in) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign apply  = accept;
  assign div_in = div_ok ? req_div : CNT_W'(MIN_DIV);
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cur_div_d = cur_div_q;
    busy_d    = busy_q;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (apply && req_imm) begin
          cur_div_d = div_in;
          clear     = 1'b1;
        end else if (apply) begin
          pending_d = div_in;
          state_d   = PENDING;
          busy_d    = 1'b1;
        end
      end
      PENDING: begin
        if (boundary) begin
          cur_div_d = pending_q;
          state_d   = IDLE;
          busy_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cur_div_q <= CNT_W'(DEFAULT_DIV);
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_div_q <= cur_div_d;
      busy_q    <= busy_d;
    end
  end

  assign cur_div = cur_div_q;
  assign busy    = busy_q;

  period_counter #(
    .CNT_W (CNT_W)
  ) u_period_counter (
    .clock_in (clock_in),
    .reset    (reset),
    .cur_div  (cur_div_q),
    .clear    (clear),
    .boundary (boundary),
    .tick_out (tick_out),
    .wave_out (wave_out)
  );

endmodule
`default_nettype wire

// File: doc/divider_rate_scheduler.md
Name: divider_rate_scheduler

Overview:
- Owns the output-rate divider of the waveform generator. Accepts divisor change requests over a valid/ready handshake.
- Applies each change only at a period boundary, so the output never shows a runt or stretched pulse. An immediate override is also available.
- Emits a registered square enable and a one-cycle period tick for the downstream sample/phase logic.

Parameters:
- CNT_W, 28: width of the counter and of every divisor.
- DEFAULT_DIV, 100000: divisor loaded at reset.
- MIN_DIV, 2: smallest legal divisor.

Ports:
- clock_in  in  1  system clock (100 MHz board clock).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  divisor change request.
- req_div  in  CNT_W  requested divisor.
- req_imm  in  1  qualifies req_valid: apply now instead of at the next boundary.
- req_ready  out  1  scheduler can accept a request.
- cur_div  out  CNT_W  divisor currently in effect.
- busy  out  1  a request has been accepted and is not yet applied.
- tick_out  out  1  one-cycle pulse per output period.
- wave_out  out  1  square output, high for the first floor(cur_div/2) cycles of each period.
- err_out  out  1  sticky rejected-request flag (only when DIV_RANGE_CHECK_EN is defined).

Behaviour:
- Reset is synchronous and active-high; one clock; every register is updated on the clock_in rising edge.
- Reset values: counter=0, cur_div=DEFAULT_DIV, state=IDLE, pending=0, tick_out=0, wave_out=0, busy=0, err_out=0. req_ready=1 (combinational: state==IDLE).
- Counter:
  - Runs 0..cur_div-1.
  - Boundary is the cycle in which counter==cur_div-1. At the following edge the counter becomes 0 and tick_out is registered to 1 for exactly one cycle.
  - wave_out is registered as (counter < cur_div/2) using integer floor, so it lags the counter by one cycle. For odd cur_div, high lasts floor(cur_div/2) cycles.
- States:
  - IDLE: req_ready=1. On req_valid && !req_imm, latch req_div into pending and go to PENDING; busy=1 from the next cycle.
  - PENDING: req_ready=0 and req_valid is ignored. At the boundary edge, cur_div<=pending, counter<=0, tick_out<=1, go to IDLE; busy=0 from the next cycle.
  - Immediate: in IDLE, req_valid && req_imm loads cur_div<=req_div and counter<=0 at that edge. tick_out does not fire and state stays IDLE. wave_out reflects the new period from the following cycle.
- Simultaneous events:
  - Request accepted in IDLE on a boundary cycle: the current boundary wraps with the old divisor. The new divisor applies at the next boundary, one full old period later.
  - Immediate request on a boundary cycle: the load wins, so counter=0, cur_div=new and tick_out=0.
- Any divisor < MIN_DIV (including 0 and 1) is clamped to MIN_DIV when DIV_RANGE_CHECK_EN is not defined.
- Reset mid-PENDING discards pending and restores DEFAULT_DIV.
- Counter arithmetic is CNT_W bits unsigned. cur_div-1 never underflows because cur_div >= MIN_DIV.

Optional Feature:
- Macro DIV_RANGE_CHECK_EN, defined:
  - A request with req_div < MIN_DIV is still handshaked (req_ready observed) but not applied.
  - State stays IDLE and err_out is set; it stays set until reset.
  - Valid requests never clear err_out.
- Not defined: no err_out port; out-of-range divisors are clamped to MIN_DIV.

Decomposition:
- Shared package div_sched_pkg:
  - CNT_W default.
  - MIN_DIV.
  - state typedef {IDLE, PENDING}.
- One natural sub-module, period_counter, holding:
  - counter, with load/clear.
  - the boundary compare.
  - the tick_out and wave_out registers.
- The scheduler FSM and handshake live in the top.

Test Plan:
- Reset with DEFAULT_DIV=10 -> cur_div=10, req_ready=1; tick_out every 10 cycles; wave_out high 5 and low 5, one cycle behind the counter.
- In IDLE mid-period (counter=3), req_div=6, req_imm=0 -> busy=1, req_ready=0; switch occurs after counter=9 wraps; next period is 6 cycles with wave high 3; busy drops.
- Request on a boundary cycle (counter=9), req_div=4 -> current period ends normally; one more 10-cycle period; then 4-cycle periods.
- req_imm=1, req_div=7 at counter=5 -> counter=0 next cycle, no tick, cur_div=7; next tick 7 cycles later; wave high 3, low 4.
- req_div=1 without macro -> cur_div=2; tick every 2 cycles and wave toggles each cycle. With DIV_RANGE_CHECK_EN -> cur_div unchanged, err_out=1 and stays set.
- reset asserted while PENDING (pending=20) -> cur_div=10, state IDLE, busy=0, outputs at reset values, no switch to 20.
